// File: rtl/bus_timer.sv
// bus_timer: memory-mapped down-counting timer behind the address bridge.
// Registers (offset = addr[4:0]): 0x00 CTRL {AUTO,EN}, 0x04 LOAD, 0x08 COUNT,
// 0x0C STATUS {EXP, write-1-to-clear}, 0x10 PRESC, 0x14-0x1C reserved (read 0).
// Build option: define TIMER_PRESCALE_EN to make PRESC a real register;
// without it PRESC is tied to 0 and a tick occurs on every enabled cycle.
module bus_timer #(
    parameter int unsigned PRESC_W  = 16,
    parameter logic [31:0] LOAD_RST = 32'd0
) (
    input  logic        clk_from_bg,
    input  logic        rst_from_bg,
    input  logic [31:0] addr_from_bg,
    input  logic        we_from_bg,
    input  logic [31:0] wdata_from_bg,
    output logic [31:0] rdata_to_bg,
    output logic        expire_pulse
);

    // RUN is exactly the EN bit of CTRL
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_reg;
    logic                auto_reg;
    logic [31:0]         load_reg;
    logic [31:0]         count_reg;
    logic                exp_reg;
    logic                pulse_reg;
    logic [PRESC_W-1:0]  pc_reg;
    logic [PRESC_W-1:0]  presc_val;

    logic [2:0]          reg_sel;
    logic                wr_ctrl;
    logic                wr_load;
    logic                wr_count;
    logic                wr_status;
    logic                tick;
    logic                tick_eff;

    // Only addr[4:2] selects a register; the rest of the address is the bridge's business
    wire unused_addr = &{1'b0, addr_from_bg[31:5], addr_from_bg[1:0]};

    assign reg_sel   = addr_from_bg[4:2];
    assign wr_ctrl   = we_from_bg && (reg_sel == 3'd0);
    assign wr_load   = we_from_bg && (reg_sel == 3'd1);
    assign wr_count  = we_from_bg && (reg_sel == 3'd2);
    assign wr_status = we_from_bg && (reg_sel == 3'd3);

`ifdef TIMER_PRESCALE_EN
    logic               wr_presc;
    logic [PRESC_W-1:0] presc_reg;

    assign wr_presc = we_from_bg && (reg_sel == 3'd4);

    // Prescaler reload value; only the low PRESC_W bits are kept
    always_ff @(posedge clk_from_bg or posedge rst_from_bg) begin
        if (rst_from_bg) begin
            presc_reg <= '0;
        end else if (wr_presc) begin
            presc_reg <= wdata_from_bg[PRESC_W-1:0];
        end
    end

    assign presc_val = presc_reg;
`else
    assign presc_val = '0;
`endif

    // Tick when the prescaler counter reaches PRESC while running
    assign tick     = (state_reg == RUN) && (pc_reg == presc_val);
    // A COUNT write in the same cycle overrides whatever the tick would have done
    assign tick_eff = tick && !wr_count;

    // Prescaler counter: runs only while enabled, restarts on tick or any CTRL write
    always_ff @(posedge clk_from_bg or posedge rst_from_bg) begin
        if (rst_from_bg) begin
            pc_reg <= '0;
        end else if (wr_ctrl || (state_reg != RUN) || tick) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_reg + 1'b1;
        end
    end

    // Reload register; an auto-reload in the same cycle still sees the old value
    always_ff @(posedge clk_from_bg or posedge rst_from_bg) begin
        if (rst_from_bg) begin
            load_reg <= LOAD_RST;
        end else if (wr_load) begin
            load_reg <= wdata_from_bg;
        end
    end

    // Count FSM: decrement on tick, expire at zero, reload or stop; bus writes layered on top
    always_ff @(posedge clk_from_bg or posedge rst_from_bg) begin
        if (rst_from_bg) begin
            state_reg <= IDLE;
            auto_reg  <= 1'b0;
            count_reg <= LOAD_RST;
            exp_reg   <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            pulse_reg <= 1'b0;
            // Clear first so that an expiry in the same cycle sets EXP again
            if (wr_status && wdata_from_bg[0]) begin
                exp_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    // COUNT holds
                end
                RUN: begin
                    if (tick_eff) begin
                        if (count_reg != 32'd0) begin
                            count_reg <= count_reg - 32'd1;
                        end else begin
                            exp_reg   <= 1'b1;
                            pulse_reg <= 1'b1;
                            if (auto_reg) begin
                                count_reg <= load_reg;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end
                    end
                end
            endcase
            if (wr_count) begin
                count_reg <= wdata_from_bg;
            end
            // Software's CTRL write takes precedence over a one-shot self-disable
            if (wr_ctrl) begin
                state_reg <= wdata_from_bg[0] ? RUN : IDLE;
                auto_reg  <= wdata_from_bg[1];
            end
        end
    end

    assign expire_pulse = pulse_reg;

    // Zero-latency read mux; unused offsets read as zero
    always_comb begin
        rdata_to_bg = 32'd0;
        case (reg_sel)
            3'd0:    rdata_to_bg = {30'd0, auto_reg, (state_reg == RUN)};
            3'd1:    rdata_to_bg = load_reg;
            3'd2:    rdata_to_bg = count_reg;
            3'd3:    rdata_to_bg = {31'd0, exp_reg};
            3'd4:    rdata_to_bg = 32'(presc_val);
            default: rdata_to_bg = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed test of bus_timer (reset, one-shot, periodic,
// collisions, address decode, prescaler option, async reset mid-count).
module tb_bus_timer;

    localparam logic [31:0] A_CTRL   = 32'hFFFF_F040;
    localparam logic [31:0] A_LOAD   = 32'hFFFF_F044;
    localparam logic [31:0] A_COUNT  = 32'hFFFF_F048;
    localparam logic [31:0] A_STATUS = 32'hFFFF_F04C;
    localparam logic [31:0] A_PRESC  = 32'hFFFF_F050;
    localparam logic [31:0] A_RES14  = 32'hFFFF_F054;
    localparam logic [31:0] A_RES18  = 32'hFFFF_F058;

`ifdef TIMER_PRESCALE_EN
    localparam int PRESC_EFF = 1;
    localparam logic [31:0] PRESC5_RD = 32'd5;
    localparam logic [31:0] PRESC1_RD = 32'd1;
`else
    localparam int PRESC_EFF = 0;
    localparam logic [31:0] PRESC5_RD = 32'd0;
    localparam logic [31:0] PRESC1_RD = 32'd0;
`endif
    // Expiry period with LOAD=4: (LOAD+1)*(PRESC+1)
    localparam int P = 5 * (PRESC_EFF + 1);

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        pulse;

    int n_cmp;
    int n_fail;

    bus_timer #(
        .PRESC_W  (16),
        .LOAD_RST (32'd0)
    ) dut (
        .clk_from_bg   (clk),
        .rst_from_bg   (rst),
        .addr_from_bg  (addr),
        .we_from_bg    (we),
        .wdata_from_bg (wdata),
        .rdata_to_bg   (rdata),
        .expire_pulse  (pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, expv);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Bus write committing on the next rising edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        $display("wr %h <= %h", a, d);
    endtask

    // Combinational read; consumes 1 time unit
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] expv);
        addr = a;
        #1;
        chk(tag, rdata, expv);
    endtask

    task automatic pulse_chk(input string tag, input logic expv);
        chk(tag, {31'd0, pulse}, {31'd0, expv});
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        we     = 1'b0;
        addr   = A_CTRL;
        wdata  = 32'd0;

        // Reset asserted before any clock edge
        #1 rst = 1'b1;
        rd_chk("rst_ctrl", A_CTRL, 32'd0);
        rd_chk("rst_status", A_STATUS, 32'd0);
        rd_chk("rst_count", A_COUNT, 32'd0);
        pulse_chk("rst_pulse", 1'b0);
        cyc();
        rst = 1'b0;
        cyc();

        // One-shot: COUNT=3, EN only
        wr(A_COUNT, 32'd3);
        wr(A_CTRL, 32'd1);
        rd_chk("os_ctrl_on", A_CTRL, 32'd1);
        cyc();
        rd_chk("os_count2", A_COUNT, 32'd2);
        pulse_chk("os_pulse_c1", 1'b0);
        cyc();
        rd_chk("os_count1", A_COUNT, 32'd1);
        pulse_chk("os_pulse_c2", 1'b0);
        cyc();
        rd_chk("os_count0", A_COUNT, 32'd0);
        pulse_chk("os_pulse_c3", 1'b0);
        cyc();
        pulse_chk("os_pulse_c4", 1'b1);
        rd_chk("os_ctrl_off", A_CTRL, 32'd0);
        rd_chk("os_exp", A_STATUS, 32'd1);
        cyc();
        pulse_chk("os_pulse_c5", 1'b0);
        rd_chk("os_count_hold", A_COUNT, 32'd0);
        rd_chk("os_exp_sticky", A_STATUS, 32'd1);

        // STATUS: write 0 has no effect, write 1 clears
        wr(A_STATUS, 32'd0);
        rd_chk("st_w0", A_STATUS, 32'd1);
        wr(A_STATUS, 32'd1);
        rd_chk("st_w1", A_STATUS, 32'd0);

        // Reserved offsets: writes ignored, reads zero
        wr(A_RES14, 32'hFFFF_FFFF);
        rd_chk("dec_ctrl", A_CTRL, 32'd0);
        rd_chk("dec_load", A_LOAD, 32'd0);
        rd_chk("dec_count", A_COUNT, 32'd0);
        rd_chk("dec_status", A_STATUS, 32'd0);
        rd_chk("dec_presc", A_PRESC, 32'd0);
        rd_chk("dec_rd14", A_RES14, 32'd0);
        rd_chk("dec_rd18", A_RES18, 32'd0);
        cyc();

        // Prescaler register (upper bits dropped when present, all ignored when absent)
        wr(A_PRESC, 32'hABCD_0005);
        rd_chk("presc5", A_PRESC, PRESC5_RD);
        wr(A_PRESC, 32'd1);
        rd_chk("presc1", A_PRESC, PRESC1_RD);

        // Periodic: LOAD=4, COUNT=4, EN+AUTO
        wr(A_LOAD, 32'd4);
        wr(A_COUNT, 32'd4);
        wr(A_CTRL, 32'd3);
        for (int k = 1; k <= 3 * P; k++) begin
            cyc();
            pulse_chk($sformatf("per_pulse_%0d", k), (k % P) == 0);
        end
        rd_chk("per_exp", A_STATUS, 32'd1);
        rd_chk("per_ctrl", A_CTRL, 32'd3);
        wr(A_STATUS, 32'd1);
        rd_chk("per_exp_clr", A_STATUS, 32'd0);

        // STATUS clear colliding with the 4th expiry: set wins
        repeat (P - 2) cyc();
        wr(A_STATUS, 32'd1);
        pulse_chk("col_pulse", 1'b1);
        rd_chk("col_exp", A_STATUS, 32'd1);
        rd_chk("col_reload", A_COUNT, 32'd4);

        // COUNT write on a tick cycle: written value wins, no decrement
        repeat (PRESC_EFF) cyc();
        wr(A_COUNT, 32'd7);
        rd_chk("col_count7", A_COUNT, 32'd7);
        repeat (PRESC_EFF + 1) cyc();
        rd_chk("col_count6", A_COUNT, 32'd6);

        // Async reset while expire_pulse is high
        wr(A_CTRL, 32'd0);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'd3);
        repeat (PRESC_EFF + 1) cyc();
        pulse_chk("ar_pulse_pre", 1'b1);
        #2 rst = 1'b1;
        #1 pulse_chk("ar_pulse", 1'b0);
        rd_chk("ar_ctrl", A_CTRL, 32'd0);
        rd_chk("ar_count", A_COUNT, 32'd0);
        rd_chk("ar_status", A_STATUS, 32'd0);
        rd_chk("ar_load", A_LOAD, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        rd_chk("ar_ctrl_after", A_CTRL, 32'd0);
        pulse_chk("ar_pulse_after", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
